// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared mesh-router types and constants (port codes, widths).
//  Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = 3;
    localparam int FLIT_W    = 16;

    typedef enum logic [PORT_W-1:0] {
        N = 3'd0,
        S = 3'd1,
        E = 3'd2,
        W = 3'd3,
        L = 3'd4
    } port_e;

    // Codes above L do not name a port.
    function automatic logic port_code_valid(input logic [PORT_W-1:0] code);
        return code <= PORT_W'(L);
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_output_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_output_allocator_if
//  Description : Request / grant / credit bundle between the input FIFOs,
//                crossbar and the output allocator.
//  Revision    : 1.0  initial release
// ============================================================================
interface noc_output_allocator_if;
    import noc_pkg::*;

    logic [NUM_PORTS-1:0]        req_valid_i;
    logic [NUM_PORTS*PORT_W-1:0] req_dest_i;
    logic [NUM_PORTS-1:0]        credit_inc_i;
    logic [NUM_PORTS-1:0]        pop_o;
    logic [NUM_PORTS-1:0]        out_enable_o;
    logic [NUM_PORTS*PORT_W-1:0] out_select_o;
    logic                        err_o;

    // Router side: presents requests and returned credits.
    modport master (
        output req_valid_i, req_dest_i, credit_inc_i,
        input  pop_o, out_enable_o, out_select_o, err_o
    );

    // Allocator side.
    modport slave (
        input  req_valid_i, req_dest_i, credit_inc_i,
        output pop_o, out_enable_o, out_select_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/noc_output_allocator_rr_pick5.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick5
//  Description : Combinational 5-way round-robin picker. Searches upward from
//                ptr, wrapping mod 5; the first asserted request wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic                 gnt_valid,
    output logic [PORT_W-1:0]    winner
);

    logic [PORT_W:0] w_idx;

    // Scan from the farthest offset down so the nearest-to-ptr hit is kept.
    always_comb begin
        gnt_valid = 1'b0;
        winner    = '0;
        w_idx     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_idx = {1'b0, ptr} + (PORT_W+1)'(k);
            if (w_idx >= (PORT_W+1)'(NUM_PORTS)) begin
                w_idx = w_idx - (PORT_W+1)'(NUM_PORTS);
            end
            if (req[w_idx[PORT_W-1:0]]) begin
                gnt_valid = 1'b1;
                winner    = w_idx[PORT_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_output_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : noc_output_allocator
//  Description : 5-port switch allocator with per-output round-robin
//                arbitration and downstream credit counting.
//  Revision    : 1.0  initial release
// ============================================================================
module noc_output_allocator
    import noc_pkg::*;
#(
    parameter int                   CREDIT_DEPTH = 4,
    parameter logic [NUM_PORTS-1:0] PORT_MASK    = 5'b11111
) (
    input  logic                   clk,
    input  logic                   rst,
    noc_output_allocator_if.slave  alloc
);

    localparam int CRED_W = $clog2(CREDIT_DEPTH + 1);

    logic [PORT_W-1:0]           w_dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]        w_legal;
    logic [NUM_PORTS-1:0]        w_illegal;
    logic [NUM_PORTS-1:0]        w_gnt_valid;
    logic [PORT_W-1:0]           w_winner [NUM_PORTS];
    logic [NUM_PORTS-1:0]        w_ovf;
    logic [NUM_PORTS-1:0]        w_pop;
    logic [NUM_PORTS-1:0]        w_en;
    logic [NUM_PORTS*PORT_W-1:0] w_sel;
    logic                        r_err;

    // Classify each input's head-flit request; U-turns and missing ports are illegal.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dest[i]    = alloc.req_dest_i[PORT_W*i +: PORT_W];
            w_legal[i]   = alloc.req_valid_i[i] && PORT_MASK[i] &&
                           port_code_valid(w_dest[i]) &&
                           PORT_MASK[w_dest[i]] &&
                           (w_dest[i] != PORT_W'(i));
            w_illegal[i] = alloc.req_valid_i[i] && PORT_MASK[i] && !w_legal[i];
        end
    end

    genvar o;
    generate
        for (o = 0; o < NUM_PORTS; o++) begin : g_out
            logic [NUM_PORTS-1:0] w_cand;
            logic [NUM_PORTS-1:0] w_req;
            logic                 w_inc;
            logic [PORT_W-1:0]    r_ptr;
            logic [CRED_W-1:0]    r_cred;

            // Legal requests aimed at this output.
            always_comb begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    w_cand[i] = w_legal[i] && (w_dest[i] == PORT_W'(o));
                end
            end

            // No credit or reset asserted: nothing is offered to the picker.
            assign w_req  = w_cand & {NUM_PORTS{(r_cred != '0) && !rst}};
            assign w_inc  = alloc.credit_inc_i[o] && PORT_MASK[o];
            assign w_ovf[o] = w_inc && !w_gnt_valid[o] &&
                              (r_cred == CRED_W'(CREDIT_DEPTH));

            rr_pick5 u_pick (
                .req       (w_req),
                .ptr       (r_ptr),
                .gnt_valid (w_gnt_valid[o]),
                .winner    (w_winner[o])
            );

            // Advance pointer past the winner and track downstream credits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr  <= '0;
                    r_cred <= CRED_W'(CREDIT_DEPTH);
                end else begin
                    if (w_gnt_valid[o]) begin
                        r_ptr <= (w_winner[o] == PORT_W'(NUM_PORTS - 1)) ? '0
                                                                         : w_winner[o] + 1'b1;
                    end
                    if (w_gnt_valid[o] && !w_inc) begin
                        r_cred <= r_cred - 1'b1;
                    end else if (!w_gnt_valid[o] && w_inc &&
                                 (r_cred != CRED_W'(CREDIT_DEPTH))) begin
                        r_cred <= r_cred + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Fan grants out to FIFO pops, output enables and crossbar selects.
    always_comb begin
        w_pop = '0;
        w_en  = '0;
        w_sel = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_gnt_valid[k]) begin
                w_en[k]                   = 1'b1;
                w_sel[PORT_W*k +: PORT_W] = w_winner[k];
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (w_winner[k] == PORT_W'(i)) begin
                        w_pop[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Sticky error: illegal request or credit return into a full counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((|w_illegal) || (|w_ovf)) begin
            r_err <= 1'b1;
        end
    end

    assign alloc.pop_o        = w_pop;
    assign alloc.out_enable_o = w_en;
    assign alloc.out_select_o = w_sel;
    assign alloc.err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_output_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_output_allocator
//  Description : Self-checking bench for noc_output_allocator; a full-mesh
//                and an edge-router (no South) instance share the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_noc_output_allocator;
    import noc_pkg::*;

    localparam int         DEPTH  = 4;
    localparam logic [4:0] MASK_A = 5'b11111;
    localparam logic [4:0] MASK_B = 5'b11101;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [4:0]  valid = '0;
    logic [14:0] dest  = '0;
    logic [4:0]  cinc  = '0;

    always #5 clk = ~clk;

    noc_output_allocator_if bus_a ();
    noc_output_allocator_if bus_b ();

    assign bus_a.req_valid_i  = valid;
    assign bus_a.req_dest_i   = dest;
    assign bus_a.credit_inc_i = cinc;
    assign bus_b.req_valid_i  = valid;
    assign bus_b.req_dest_i   = dest;
    assign bus_b.credit_inc_i = cinc;

    noc_output_allocator #(.CREDIT_DEPTH(DEPTH), .PORT_MASK(MASK_A)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .alloc (bus_a.slave)
    );

    noc_output_allocator #(.CREDIT_DEPTH(DEPTH), .PORT_MASK(MASK_B)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .alloc (bus_b.slave)
    );

    // Reference state: per DUT, per output.
    int ptr_m  [2][5];
    int cred_m [2][5];
    bit err_m  [2];
    int win_m  [2][5];

    int nchecks = 0;
    int nerr    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] mask_of(input int d);
        return (d == 0) ? MASK_A : MASK_B;
    endfunction

    function automatic int dest_of(input int i);
        return int'((dest >> (3 * i)) & 15'h7);
    endfunction

    function automatic bit legal(input int d, input int i);
        logic [4:0] m;
        int         ds;
        m  = mask_of(d);
        ds = dest_of(i);
        if (!valid[i] || !m[i] || ds > 4 || ds == i) return 1'b0;
        return m[ds];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            err_m[d] = 1'b0;
            for (int k = 0; k < 5; k++) begin
                ptr_m[d][k]  = 0;
                cred_m[d][k] = DEPTH;
            end
        end
    endtask

    // Expected winner per output from the current state and inputs.
    task automatic predict(input int d);
        for (int k = 0; k < 5; k++) begin
            win_m[d][k] = -1;
            if (!rst && cred_m[d][k] > 0) begin
                for (int s = 0; s < 5; s++) begin
                    int w;
                    w = (ptr_m[d][k] + s) % 5;
                    if (win_m[d][k] < 0 && legal(d, w) && dest_of(w) == k) win_m[d][k] = w;
                end
            end
        end
    endtask

    task automatic update(input int d);
        logic [4:0] m;
        m = mask_of(d);
        for (int i = 0; i < 5; i++) begin
            if (valid[i] && m[i] && !legal(d, i)) err_m[d] = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            bit g, inc;
            g   = (win_m[d][k] >= 0);
            inc = cinc[k] && m[k];
            if (g) ptr_m[d][k] = (win_m[d][k] + 1) % 5;
            if (g && !inc) cred_m[d][k]--;
            else if (!g && inc) begin
                if (cred_m[d][k] == DEPTH) err_m[d] = 1'b1;
                else cred_m[d][k]++;
            end
        end
    endtask

    task automatic check_dut(input int d, input string tag);
        logic [4:0]  ep, ee, ap, ae;
        logic [14:0] es, as_;
        logic        aerr;
        ep = '0; ee = '0; es = '0;
        for (int k = 0; k < 5; k++) begin
            if (win_m[d][k] >= 0) begin
                ep[win_m[d][k]] = 1'b1;
                ee[k]           = 1'b1;
                es[3*k +: 3]    = 3'(win_m[d][k]);
            end
        end
        ap   = (d == 0) ? bus_a.pop_o        : bus_b.pop_o;
        ae   = (d == 0) ? bus_a.out_enable_o : bus_b.out_enable_o;
        as_  = (d == 0) ? bus_a.out_select_o : bus_b.out_select_o;
        aerr = (d == 0) ? bus_a.err_o        : bus_b.err_o;
        check($sformatf("%s_pop%0d", tag, d), 32'(ap),   32'(ep));
        check($sformatf("%s_en%0d",  tag, d), 32'(ae),   32'(ee));
        check($sformatf("%s_sel%0d", tag, d), 32'(as_),  32'(es));
        check($sformatf("%s_err%0d", tag, d), 32'(aerr), 32'(err_m[d]));
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 unit later.
    task automatic observe(input string tag);
        #1;
        for (int d = 0; d < 2; d++) begin
            predict(d);
            check_dut(d, tag);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_reset();
        else for (int d = 0; d < 2; d++) update(d);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int code);
        valid[i]     = 1'b1;
        dest[3*i +: 3] = 3'(code);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0; cinc = '0;
        observe("rst");
        advance();
        rst = 1'b0;
    endtask

    initial begin
        // Reset with every input requesting.
        rst   = 1'b1;
        valid = 5'b11111;
        for (int i = 0; i < 5; i++) set_req(i, (i + 1) % 5);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        observe("rst");
        check("rst_pop", 32'(bus_a.pop_o), 32'h0);
        check("rst_en",  32'(bus_a.out_enable_o), 32'h0);
        check("rst_err", 32'(bus_a.err_o), 32'h0);
        advance();
        observe("rst");
        advance();
        rst = 1'b0; valid = '0;
        observe("idle");
        advance();

        // Single grant N -> E.
        set_req(0, 2);
        observe("t2");
        check("t2_pop", 32'(bus_a.pop_o), 32'h01);
        check("t2_en",  32'(bus_a.out_enable_o), 32'h04);
        check("t2_sel", 32'(bus_a.out_select_o[8:6]), 32'h0);
        advance();
        valid = '0;

        // Round-robin contention on E: N, W, L, then pointer back at N.
        do_reset();
        set_req(0, 2); set_req(3, 2); set_req(4, 2);
        observe("t3a"); check("t3_first",  32'(bus_a.out_select_o[8:6]), 32'h0); advance();
        valid[0] = 1'b0;
        observe("t3b"); check("t3_second", 32'(bus_a.out_select_o[8:6]), 32'h3); advance();
        valid[3] = 1'b0;
        observe("t3c"); check("t3_third",  32'(bus_a.out_select_o[8:6]), 32'h4); advance();
        valid = '0;
        set_req(0, 2); set_req(3, 2);
        observe("t3d"); check("t3_ptr0",   32'(bus_a.out_select_o[8:6]), 32'h0); advance();
        valid = '0;

        // Credit exhaustion with L -> E held.
        do_reset();
        set_req(4, 2);
        for (int n = 0; n < 4; n++) begin
            observe("t4"); check("t4_grant", 32'(bus_a.out_enable_o[2]), 32'h1); advance();
        end
        cinc = 5'b00100;
        observe("t4e"); check("t4_empty", 32'(bus_a.out_enable_o[2]), 32'h0); advance();
        cinc = '0;
        observe("t4r"); check("t4_refill", 32'(bus_a.out_enable_o[2]), 32'h1); advance();

        // Grant and credit together at cred=1 leave cred at 1.
        valid = '0; cinc = 5'b00100;
        observe("t5a"); advance();
        set_req(4, 2);
        observe("t5b"); check("t5_both", 32'(bus_a.out_enable_o[2]), 32'h1); advance();
        cinc = '0;
        observe("t5c"); check("t5_last", 32'(bus_a.out_enable_o[2]), 32'h1); advance();
        observe("t5d"); check("t5_empty", 32'(bus_a.out_enable_o[2]), 32'h0); advance();
        valid = '0;

        // Credit return into a full counter.
        do_reset();
        cinc = 5'b00100;
        observe("t5o"); check("t5_pre_err", 32'(bus_a.err_o), 32'h0); advance();
        cinc = '0;
        observe("t5p"); check("t5_ovf_err", 32'(bus_a.err_o), 32'h1); advance();

        // Masked South, U-turn, and a normal N -> W grant together.
        do_reset();
        set_req(3, 1); set_req(2, 2); set_req(0, 3);
        observe("t6");
        check("t6_pop", 32'(bus_b.pop_o), 32'h01);
        check("t6_en",  32'(bus_b.out_enable_o), 32'h08);
        advance();
        valid = '0;
        observe("t6e"); check("t6_err", 32'(bus_b.err_o), 32'h1); advance();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                int c;
                c = $urandom_range(0, 5);
                if (c == 5) c = $urandom_range(5, 7);
                dest[3*i +: 3] = 3'(c);
            end
            cinc = 5'($urandom & $urandom & $urandom);
            observe("rnd");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_output_allocator.md
# noc_output_allocator

Per-router switch allocator and credit scheduler for the 5-port (N/S/E/W/L) mesh router. Each cycle it takes the head-flit routing requests of the five input FIFOs and grants at most one input to each output port. Arbitration is round-robin per output, and a grant requires a downstream credit. It drives input-FIFO pops, output-port enables and crossbar select codes, and it replaces the fixed rotating-turn arbitration in the router top.

## Interface
Parameters:
- `CREDIT_DEPTH`, default 4: downstream buffer slots per output; credit counter reset value and maximum.
- `PORT_MASK`, default 5'b11111: bit p = 1 means port p is present. Edge routers clear the missing port's bit (e.g. 5'b11101 for no South).

Ports:
- `clk`, in, 1: clock. The block has one clock. Reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset.
- `req_valid_i`, in, 5: input p has a head flit requesting an output.
- `req_dest_i`, in, 15: 5 × 3-bit destination port code. Slice p is bits [3p+2:3p].
- `credit_inc_i`, in, 5: downstream of output p returned one credit this cycle.
- `pop_o`, out, 5: input p was granted; its FIFO shifts at this clock edge.
- `out_enable_o`, out, 5: output p sends the crossbar data this cycle.
- `out_select_o`, out, 15: 5 × 3-bit source port code for output p's crossbar mux.
- `err_o`, out, 1: sticky protocol-error flag.

Port codes: N=0, S=1, E=2, W=3, L=4. Codes 5–7 are invalid.

## Operation
- **Per-output state**
  - `ptr[o]`: 3-bit round-robin pointer, range 0..4.
  - `cred[o]`: credit counter, range 0..CREDIT_DEPTH.
- **Legal request.** Input i's request is legal when all of the following hold:
  - `req_valid_i[i]` = 1;
  - `PORT_MASK[i]` = 1;
  - `dest` ≤ 4;
  - `PORT_MASK[dest]` = 1;
  - `dest` ≠ i (U-turns are forbidden, including L→L).
- **Illegal request.** An illegal request with `req_valid_i[i]` = 1 and `PORT_MASK[i]` = 1 is never granted and sets `err_o`.
- **Arbitration for output o** (combinational from current state):
  - Candidates are the legal requests with `dest` = o.
  - If `cred[o]` = 0, no grant is made.
  - Otherwise, search inputs starting at `ptr[o]`, ascending and wrapping mod 5. The first candidate found wins.
- **Grant to input w on output o:**
  - `pop_o[w]` = 1 and `out_enable_o[o]` = 1.
  - `out_select_o[o]` = w.
- **No grant on output o:** `out_enable_o[o]` = 0 and `out_select_o[o]` = 0.
- **Pointer update at the clock edge:** after a grant, `ptr[o]` ← (w+1) mod 5. Without a grant it holds.
- **Credit update at the clock edge, case by case:**
  - Grant only: `cred` − 1.
  - `credit_inc_i` only: `cred` + 1.
  - Both together: unchanged.
  - `credit_inc_i` without a grant when `cred` = CREDIT_DEPTH: saturate (hold) and set `err_o`.
- **Masked ports:** masked outputs never enable. `credit_inc_i` on a masked port is ignored.
- **`err_o`:** stays set until reset.

## Timing
- **Zero-cycle grant.** `pop_o`, `out_enable_o` and `out_select_o` are combinational from `req_*` and registered state, valid in the same cycle as the request.
- **State update.** State updates at the rising edge. An input re-presents its next head flit at cycle t+1.
- **Credit latency.** A credit returned in cycle t is usable for a grant in cycle t+1.
- **During reset** (`rst` = 1), the combinational outputs are forced to 0 regardless of requests: `pop_o` = 0, `out_enable_o` = 0, `out_select_o` = 0.
- **Reset values at the first edge with `rst`:**
  - `err_o` = 0;
  - `ptr` = 0 for all outputs;
  - `cred` = CREDIT_DEPTH for all outputs.
- **Reset mid-operation** abandons all state. Credits in flight are lost by design; downstream buffers are reset together with this block.

## Structure
- Shared package `noc_pkg`:
  - `port_e` enum (N, S, E, W, L);
  - `NUM_PORTS` = 5;
  - `PORT_W` = 3;
  - `FLIT_W` = 16.
- Sub-module `rr_pick5`: combinational 5-way round-robin picker with 5-bit request vector and 3-bit pointer inputs, producing `gnt_valid` and a 3-bit winner. Instantiated once per output.
- The credit counters and pointers live in the top generate loop.

## Test plan
1. **Reset check.** Hold `rst` for 2 cycles with all requests high, then release with no requests.
   - During reset: `pop_o` = 0, `out_enable_o` = 0, `err_o` = 0.
   - `cred[*]` = 4 (inspect via a 5th-grant check).
2. **Single grant.** N requests E (dest = 2).
   - Same cycle: `pop_o` = 5'b00001, `out_enable_o` = 5'b00100, `out_select_o[E]` = 0.
   - Next cycle: `cred[E]` = 3.
3. **Round-robin contention.** From reset, N, W and L all request E for 3 cycles, each dropping its request after it is granted.
   - Grants in order: N (0), then W (3), then L (4).
   - Final `ptr[E]` = 0.
4. **Credit exhaustion.** L requests E continuously, with no `credit_inc_i`.
   - 4 grants, then `out_enable_o[E]` = 0.
   - Pulse `credit_inc_i[E]` → grant in the following cycle.
5. **Simultaneous events and overflow.**
   - At `cred[E]` = 1, a grant plus `credit_inc_i[E]` → `cred` stays 1.
   - At `cred[E]` = 4, `credit_inc_i[E]` alone → `cred` stays 4 and `err_o` = 1.
6. **Masked port and illegal requests.** Set `PORT_MASK` = 5'b11101.
   - W requests S → no grant, `err_o` = 1.
   - E requests E (U-turn) → no grant.
   - Concurrently, N→W is granted normally.
